freq_sweep_ctrl: RTL

FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

---
 rtl/freq_sweep_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep controller: steps a registered frequency word from f_start to f_stop,
// holding each value for dwell+1 cycles, as a single up-sweep or a continuous triangle.
module freq_sweep_ctrl #(
    parameter int unsigned freq_width  = 12,
    parameter int unsigned dwell_width = 16
) (
    input  logic                   clock_i,
    input  logic                   resetn_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   hold_i,
    input  logic                   mode_i,
    input  logic [freq_width-1:0]  f_start_i,
    input  logic [freq_width-1:0]  f_stop_i,
    input  logic [freq_width-1:0]  f_step_i,
    input  logic [dwell_width-1:0] dwell_i,
    output logic [freq_width-1:0]  freq_o,
    output logic                   busy_o,
    output logic                   dir_o,
    output logic                   done_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    state_e                 state_q, state_d;
    logic [freq_width-1:0]  freq_q, freq_d;
    logic                   dir_q, dir_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [dwell_width-1:0] cnt_q, cnt_d;

    logic [freq_width-1:0]  start_q, start_d;
    logic [freq_width-1:0]  stop_q, stop_d;
    logic [freq_width-1:0]  step_q, step_d;
    logic [dwell_width-1:0] dwell_q, dwell_d;
    logic                   mode_q, mode_d;

    logic [freq_width:0]    up_sum;
    logic [freq_width:0]    dn_diff;
    logic [freq_width-1:0]  up_next;
    logic [freq_width-1:0]  dn_next;
    logic                   cfg_ok;
    logic                   advance;

    // One extra bit catches both overflow past f_stop and underflow below zero.
    always_comb begin
        up_sum  = {1'b0, freq_q} + {1'b0, step_q};
        dn_diff = {1'b0, freq_q} - {1'b0, step_q};
        up_next = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[freq_width-1:0];
        dn_next = (dn_diff[freq_width] || (dn_diff[freq_width-1:0] < start_q)) ?
                  start_q : dn_diff[freq_width-1:0];
        cfg_ok  = (f_step_i != '0) && (f_start_i <= f_stop_i);
    end

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        advance = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (abort_i) begin
                    freq_d = '0;
                    dir_d  = 1'b0;
                end else if (start_i) begin
                    if (cfg_ok) begin
                        start_d = f_start_i;
                        stop_d  = f_stop_i;
                        step_d  = f_step_i;
                        dwell_d = dwell_i;
                        mode_d  = mode_i;
                        freq_d  = f_start_i;
                        cnt_d   = dwell_i;
                        dir_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = StRun;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (abort_i) begin
                    state_d = StIdle;
                    freq_d  = '0;
                    dir_d   = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (hold_i) begin
                    state_d = StPause;
                end else begin
                    advance = 1'b1;
                end
            end
            StPause: begin
                if (abort_i) begin
                    state_d = StIdle;
                    freq_d  = '0;
                    dir_d   = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (!hold_i) begin
                    // The resume edge counts as a run cycle so a pause costs exactly its length.
                    state_d = StRun;
                    advance = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                cnt_d = dwell_q;
                if (!mode_q) begin
                    if (freq_q == stop_q) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        freq_d = up_next;
                    end
                end else if (!dir_q) begin
                    if (freq_q == stop_q) begin
                        dir_d  = 1'b1;
                        freq_d = dn_next;
                    end else begin
                        freq_d = up_next;
                    end
                end else begin
                    if (freq_q == start_q) begin
                        dir_d  = 1'b0;
                        freq_d = up_next;
                    end else begin
                        freq_d = dn_next;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= StIdle;
            freq_q  <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
        end
    end

    assign freq_o = freq_q;
    assign busy_o = busy_q;
    assign dir_o  = dir_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule
